// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM arbiter.
//   - FSM state encoding (IDLE / WAIT / RESP)
//   - SDRAM word-interface widths (address, data, byte mask)
//   - Port-ID width and the largest supported number of requesters
package sdram_pkg;

  localparam int ADDR_W    = 25;
  localparam int DATA_W    = 32;
  localparam int MASK_W    = 4;
  localparam int ID_W      = 2;
  localparam int MAX_PORTS = 4;  // 2**ID_W; request vectors are padded to this

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector.
// Ports:
//   req        in  MAX_PORTS  request vector (bits >= NUM_PORTS are ignored)
//   last_grant in  ID_W       most recently granted port
//   winner     out ID_W       first requesting port after last_grant
//   found      out 1          any port among 0..NUM_PORTS-1 requesting
module rr_picker
  import sdram_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic [MAX_PORTS-1:0] req,
  input  logic [ID_W-1:0]      last_grant,
  output logic [ID_W-1:0]      winner,
  output logic                 found
);

  logic [ID_W-1:0] idx;

  // Walk from last_grant+1 around the ring; the first hit wins, so
  // last_grant itself is considered last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      idx = ID_W'((int'(last_grant) + off) % NUM_PORTS);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin arbiter sharing one SDRAM controller word
// interface between NUM_PORTS requesters.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   req_valid/addr/din/wmask     per-port requests (packed, port i at slice i)
//   req_ready                    one-hot, one-cycle completion pulse
//   req_dout                     shared read data, valid with req_ready
//   mem_valid/addr/din/wmask     request toward the controller (registered)
//   mem_dout, mem_ready          controller read data and completion pulse
//   busy                         FSM not in IDLE
//   grant_id                     current or last granted port
//   timeout_err                  sticky watchdog flag
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_din,
  input  logic [NUM_PORTS*MASK_W-1:0] req_wmask,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic [DATA_W-1:0]           req_dout,
  output logic                        mem_valid,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_din,
  output logic [MASK_W-1:0]           mem_wmask,
  input  logic [DATA_W-1:0]           mem_dout,
  input  logic                        mem_ready,
  output logic                        busy,
  output logic [ID_W-1:0]             grant_id,
  output logic                        timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_t state_reg, state_next;
  logic [ID_W-1:0]  last_grant_reg;
  logic [CNT_W-1:0] wd_cnt_reg;
  logic             grant_en, done_en;
  logic [ID_W-1:0]  pick_id;
  logic             pick_found;

  // Unpack the request buses into per-port arrays padded to MAX_PORTS so
  // that a full ID_W-bit index is always in range.
  logic [ADDR_W-1:0]    addr_arr [MAX_PORTS];
  logic [DATA_W-1:0]    din_arr  [MAX_PORTS];
  logic [MASK_W-1:0]    mask_arr [MAX_PORTS];
  logic [MAX_PORTS-1:0] valid_pad;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_PORTS; gi++) begin : g_port
      if (gi < NUM_PORTS) begin : g_used
        assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign din_arr[gi]   = req_din[gi*DATA_W +: DATA_W];
        assign mask_arr[gi]  = req_wmask[gi*MASK_W +: MASK_W];
        assign valid_pad[gi] = req_valid[gi];
      end else begin : g_unused
        assign addr_arr[gi]  = '0;
        assign din_arr[gi]   = '0;
        assign mask_arr[gi]  = '0;
        assign valid_pad[gi] = 1'b0;
      end
    end
  endgenerate

  rr_picker #(
    .NUM_PORTS (NUM_PORTS)
  ) u_picker (
    .req        (valid_pad),
    .last_grant (last_grant_reg),
    .winner     (pick_id),
    .found      (pick_found)
  );

  // Next-state logic. RESP exists so that a port is never re-granted in
  // the cycle its req_ready pulse is visible.
  always_comb begin
    state_next = state_reg;
    grant_en   = 1'b0;
    done_en    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pick_found) begin
          grant_en   = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          done_en    = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= ID_W'(NUM_PORTS - 1);
      wd_cnt_reg     <= '0;
      req_ready      <= '0;
      req_dout       <= '0;
      mem_valid      <= 1'b0;
      mem_addr       <= '0;
      mem_din        <= '0;
      mem_wmask      <= '0;
      busy           <= 1'b0;
      grant_id       <= '0;
      timeout_err    <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy      <= (state_next != ST_IDLE);
      req_ready <= '0;

      if (grant_en) begin
        mem_valid      <= 1'b1;
        mem_addr       <= addr_arr[pick_id];
        mem_din        <= din_arr[pick_id];
        mem_wmask      <= mask_arr[pick_id];
        grant_id       <= pick_id;
        last_grant_reg <= pick_id;
        wd_cnt_reg     <= '0;
      end

      // Watchdog counts WAIT cycles and saturates; the flag rises on the
      // same edge the count reaches TIMEOUT_CYCLES. The transaction keeps
      // waiting regardless.
      if (state_reg == ST_WAIT && wd_cnt_reg != CNT_MAX) begin
        wd_cnt_reg <= wd_cnt_reg + CNT_W'(1);
        if (wd_cnt_reg == CNT_MAX - CNT_W'(1)) begin
          timeout_err <= 1'b1;
        end
      end

      if (done_en) begin
        mem_valid <= 1'b0;
        req_dout  <= mem_dout;
        req_ready <= NUM_PORTS'(1) << grant_id;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed testbench for sdram_arbiter (2 ports,
// TIMEOUT_CYCLES=16). The bench plays the controller by driving
// mem_ready/mem_dout at fixed cycles; expected values are hand-computed.
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int NP = 2;
  localparam int TO = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NP-1:0]        req_valid;
  logic [NP*ADDR_W-1:0] req_addr;
  logic [NP*DATA_W-1:0] req_din;
  logic [NP*MASK_W-1:0] req_wmask;
  logic [NP-1:0]        req_ready;
  logic [DATA_W-1:0]    req_dout;
  logic                 mem_valid;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_din;
  logic [MASK_W-1:0]    mem_wmask;
  logic [DATA_W-1:0]    mem_dout;
  logic                 mem_ready;
  logic                 busy;
  logic [ID_W-1:0]      grant_id;
  logic                 timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .NUM_PORTS      (NP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_din     (req_din),
    .req_wmask   (req_wmask),
    .req_ready   (req_ready),
    .req_dout    (req_dout),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_wmask   (mem_wmask),
    .mem_dout    (mem_dout),
    .mem_ready   (mem_ready),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled and inputs driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [24:0] a, input logic [31:0] d, input logic [3:0] m);
    req_addr[p*ADDR_W +: ADDR_W]  = a;
    req_din[p*DATA_W +: DATA_W]   = d;
    req_wmask[p*MASK_W +: MASK_W] = m;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_din"}, mem_din, 32'd0);
    check({tag, "_mem_wmask"}, 32'(mem_wmask), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_req_dout"}, req_dout, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check({tag, "_timeout"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_din   = '0;
    req_wmask = '0;
    mem_dout  = '0;
    mem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_reset_outputs("rst");

    // ---- single read, port 0 (cycle 0 = request presented in IDLE) ----
    set_port(0, 25'h0000100, 32'h0, 4'h0);
    req_valid = 2'b01;
    check("rd_c0_mem_valid", 32'(mem_valid), 32'd0);
    tick();  // cycle 1
    check("rd_c1_mem_valid", 32'(mem_valid), 32'd1);
    check("rd_c1_mem_addr", 32'(mem_addr), 32'h0000100);
    check("rd_c1_mem_wmask", 32'(mem_wmask), 32'd0);
    check("rd_c1_grant", 32'(grant_id), 32'd0);
    check("rd_c1_busy", 32'(busy), 32'd1);
    repeat (9) tick();  // cycle 10
    mem_dout  = 32'hDEADBEEF;
    mem_ready = 1'b1;
    check("rd_c10_req_ready", 32'(req_ready), 32'd0);
    tick();  // cycle 11
    check("rd_c11_req_ready", 32'(req_ready), 32'b01);
    check("rd_c11_req_dout", req_dout, 32'hDEADBEEF);
    check("rd_c11_mem_valid", 32'(mem_valid), 32'd0);
    $display("txn read port0 addr=0x0000100 dout=0x%08h", req_dout);
    mem_ready = 1'b0;
    mem_dout  = 32'h0;
    req_valid = 2'b00;
    tick();  // cycle 12, back in IDLE
    check("rd_c12_req_ready", 32'(req_ready), 32'd0);
    check("rd_c12_busy", 32'(busy), 32'd0);
    check("rd_c12_dout_hold", req_dout, 32'hDEADBEEF);
    tick();
    check("drop_no_regrant_mv", 32'(mem_valid), 32'd0);
    check("drop_no_regrant_busy", 32'(busy), 32'd0);

    // ---- write forwarding, port 1; inputs scrambled after grant ----
    set_port(1, 25'h1FFFFFC, 32'h12345678, 4'b0011);
    req_valid = 2'b10;
    tick();
    check("wr_grant", 32'(grant_id), 32'd1);
    check("wr_mem_addr", 32'(mem_addr), 32'h1FFFFFC);
    check("wr_mem_din", mem_din, 32'h12345678);
    check("wr_mem_wmask", 32'(mem_wmask), 32'h3);
    set_port(1, 25'h0, 32'hFFFFFFFF, 4'hF);
    repeat (3) tick();
    check("wr_hold_addr", 32'(mem_addr), 32'h1FFFFFC);
    check("wr_hold_din", mem_din, 32'h12345678);
    check("wr_hold_wmask", 32'(mem_wmask), 32'h3);
    check("wr_hold_valid", 32'(mem_valid), 32'd1);
    mem_dout  = 32'hCAFEF00D;
    mem_ready = 1'b1;
    tick();
    check("wr_req_ready", 32'(req_ready), 32'b10);
    check("wr_req_dout", req_dout, 32'hCAFEF00D);
    $display("txn write port1 addr=0x1FFFFFC din=0x12345678 wmask=0x3");
    mem_ready = 1'b0;
    req_valid = 2'b00;
    tick();

    // ---- contention from reset: both ports request continuously ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_port(0, 25'h0000010, 32'h0, 4'h0);
    set_port(1, 25'h0000020, 32'h0, 4'h0);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic [1:0]  exp_id;
      logic [24:0] exp_addr;
      exp_id   = 2'(k % 2);
      exp_addr = (exp_id == 2'd0) ? 25'h0000010 : 25'h0000020;
      tick();
      check($sformatf("rr%0d_grant", k), 32'(grant_id), 32'(exp_id));
      check($sformatf("rr%0d_addr", k), 32'(mem_addr), 32'(exp_addr));
      tick();
      tick();
      mem_dout  = 32'(k + 32'hA0);
      mem_ready = 1'b1;
      tick();
      check($sformatf("rr%0d_ready", k), 32'(req_ready), 32'd1 << exp_id);
      check($sformatf("rr%0d_dout", k), req_dout, 32'(k + 32'hA0));
      $display("txn contention %0d port%0d dout=0x%08h", k, grant_id, req_dout);
      mem_ready = 1'b0;
      tick();
    end
    req_valid = 2'b00;
    tick();
    check("rr_idle_busy", 32'(busy), 32'd0);

    // ---- watchdog: controller silent for 40 cycles ----
    set_port(0, 25'h0000040, 32'h0, 4'h0);
    req_valid = 2'b01;
    tick();  // cycle 1 = first WAIT cycle
    check("wd_c1_mem_valid", 32'(mem_valid), 32'd1);
    repeat (15) tick();  // cycle 16
    check("wd_c16_err", 32'(timeout_err), 32'd0);
    tick();  // cycle 17, 16 WAIT cycles elapsed
    check("wd_c17_err", 32'(timeout_err), 32'd1);
    check("wd_c17_mem_valid", 32'(mem_valid), 32'd1);
    repeat (23) tick();  // cycle 40
    check("wd_c40_req_ready", 32'(req_ready), 32'd0);
    mem_dout  = 32'h00000055;
    mem_ready = 1'b1;
    tick();  // cycle 41
    check("wd_c41_req_ready", 32'(req_ready), 32'b01);
    check("wd_c41_dout", req_dout, 32'h55);
    $display("txn watchdog port0 dout=0x%08h timeout_err=%0d", req_dout, timeout_err);
    mem_ready = 1'b0;
    req_valid = 2'b00;
    tick();
    tick();
    check("wd_sticky", 32'(timeout_err), 32'd1);

    // ---- reset during WAIT, then stray mem_ready in IDLE ----
    set_port(1, 25'h0000080, 32'h000000AA, 4'h1);
    req_valid = 2'b10;
    tick();
    check("rw_mem_valid", 32'(mem_valid), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    req_valid = 2'b00;
    check_reset_outputs("rw");
    mem_dout  = 32'h77777777;
    mem_ready = 1'b1;
    tick();
    check("stray_req_ready", 32'(req_ready), 32'd0);
    check("stray_busy", 32'(busy), 32'd0);
    mem_ready = 1'b0;
    tick();
    check("stray_req_ready2", 32'(req_ready), 32'd0);
    check("stray_dout", req_dout, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Round-robin arbiter that shares the single-port `mt48lc16m16a2_ctrl` SDRAM controller between `NUM_PORTS` requesters (CPU instruction fetch, CPU data, DMA/video). It sits between the requesters and the controller's `valid`/`ready` word interface. It latches one request at a time, forwards it to the controller, and routes the completion pulse and read data back to the owning port. A watchdog counter flags stalled transactions.

## Interface
Parameters:
- `NUM_PORTS`, 2: number of requesters, legal range 2–4.
- `TIMEOUT_CYCLES`, 4096: cycles in WAIT before the `timeout_err` flag is set.

Ports:
- `clk`  in  1  sole clock. It also drives the SDRAM controller.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_PORTS  per-port request. The requester holds it high until its `req_ready` pulse.
- `req_addr`  in  NUM_PORTS*25  byte addresses. Port i occupies bits [25i+24:25i].
- `req_din`  in  NUM_PORTS*32  write data. Port i occupies [32i+31:32i].
- `req_wmask`  in  NUM_PORTS*4  byte write enables. A value of 0 means read.
- `req_ready`  out  NUM_PORTS  one-hot, one-cycle completion pulse.
- `req_dout`  out  32  read data. Shared by all ports; valid with `req_ready`.
- `mem_valid`  out  1  request to the controller.
- `mem_addr`  out  25  forwarded to the controller.
- `mem_din`  out  32  forwarded to the controller.
- `mem_wmask`  out  4  forwarded to the controller.
- `mem_dout`  in  32  controller read data.
- `mem_ready`  in  1  controller one-cycle completion pulse.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `grant_id`  out  2  index of the current or last granted port.
- `timeout_err`  out  1  sticky watchdog flag. Cleared only by `reset`.

## Operation
- FSM states:
  - IDLE. If any `req_valid` is high, select a winner by round-robin, latch that port's addr/din/wmask into the `mem_*` registers, set `mem_valid`=1, store `grant_id`, and go to WAIT.
  - WAIT. Hold all `mem_*` values stable. On `mem_ready`: clear `mem_valid`, register `req_dout`←`mem_dout`, pulse `req_ready[grant_id]`, and go to RESP.
  - RESP. One cycle during which the `req_ready` pulse is visible. Then go to IDLE.
- Round-robin rule: search starts at `(last_grant+1) mod NUM_PORTS` and takes the first asserted `req_valid`. `last_grant` updates only on grant. After reset, `last_grant`=NUM_PORTS-1, so port 0 has first priority.
- Requests are latched at grant. Requester inputs are ignored after grant until that port's `req_ready`.
- A port is never granted in the cycle its `req_ready` is high. The requester must drop or replace `req_valid` in the cycle after its pulse.
- `req_dout` is updated only on completion and holds its value otherwise, including after writes, where it carries whatever the controller drives.
- Watchdog:
  - The counter clears on entry to WAIT and increments each WAIT cycle, saturating at `TIMEOUT_CYCLES`.
  - When it reaches `TIMEOUT_CYCLES`, `timeout_err` is set.
  - The transaction is not aborted; the FSM keeps waiting for `mem_ready`.
- `mem_ready` outside WAIT is ignored and causes no pulse.
- Reset mid-transaction: the FSM returns to IDLE and all outputs return to their reset values. The controller shares the same reset source, so no orphaned completion arrives.
- Reset values: `mem_valid`=0, `mem_addr`=0, `mem_din`=0, `mem_wmask`=0, `req_ready`=0, `req_dout`=0, `busy`=0, `grant_id`=0, `timeout_err`=0, counter=0.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- A request arriving at cycle 0 (FSM in IDLE) produces `mem_valid`=1 at cycle 1.
- `mem_ready` seen at cycle k (sampled in WAIT) produces `req_ready`/`req_dout` at k+1 and `mem_valid`=0 at k+1. The controller therefore never sees `valid` with its own `ready` high twice.
- The earliest next grant is decided at cycle k+2, giving `mem_valid` at k+3.
- Arbiter overhead is 3 cycles per transaction on top of controller latency.
- Simultaneous requests in IDLE: exactly one is granted; the others wait. With all ports continuously requesting, grants cycle 0,1,…,N-1,0.

## Structure
- Shared package `sdram_pkg`:
  - FSM state encoding (IDLE/WAIT/RESP).
  - SDRAM address width (25) and data width (32).
  - Port-ID width localparam.
- One sub-module, `rr_picker`: combinational round-robin selector. Inputs are the request vector and `last_grant`; outputs are the winner index and a found flag.
- Top level contains the FSM, mux/latch registers, demux, and watchdog.

## Test plan
- Single read: port 0 reads addr 0x0000100; model returns `mem_ready` after 10 cycles with 0xDEADBEEF → `mem_valid` at cycle 1, `req_ready`=2'b01 one cycle after `mem_ready`, `req_dout`=0xDEADBEEF, `mem_valid` low the same cycle.
- Write forwarding: port 1 writes din=0x12345678, wmask=4'b0011, addr 0x1FFFFFC → `mem_*` carry exactly these values, stable through WAIT; `req_ready`=2'b10.
- Contention: both ports assert together from reset and stay asserted → grant order 0,1,0,1 over 4 transactions; `grant_id` matches; no port is double-granted back-to-back while the other waits.
- Requester drops valid the cycle after its pulse, other port idle → no spurious re-grant; `busy`=0 from the cycle after RESP.
- Watchdog: TIMEOUT_CYCLES=16, model withholds `mem_ready` for 40 cycles → `timeout_err`=1 at WAIT cycle 16 and stays set; completion still delivered at cycle 41; flag clears only on `reset`.
- Reset in WAIT with `mem_valid`=1 → next cycle all outputs are at reset values; a stray `mem_ready` in IDLE produces no `req_ready`.
